// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants and state encoding for the OAM DMA arbiter.
package oam_dma_arbiter_pkg;

    localparam int          DMA_LEN       = 160;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OPEN_ADDR_MIN = 16'hFF00;
    localparam logic [7:0]  DMA_LAST_IDX  = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RD   = 2'd1,
        DMA_WR   = 2'd2
    } dmaState_t;

    // IO registers and HRAM stay reachable by the CPU while a DMA runs.
    function automatic logic isOpenAddr(input logic [15:0] addr);
        return addr >= OPEN_ADDR_MIN;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Arbitrates the single MMU port between the CPU and the OAM DMA engine.
// The DMA alternates read-source / write-OAM cycles; CPU accesses to
// IO/HRAM pre-empt it for one cycle, all other CPU accesses are blocked.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuReq,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oCpuData,
    input  logic [7:0]  iMmuData,
    output logic [15:0] oMmuAddr,
    output logic [7:0]  oMmuData,
    output logic        oMmuWe,
    output logic        oDmaActive,
    output logic        oDmaDone
);

    dmaState_t   rState;
    dmaState_t   wNextState;
    logic [7:0]  rIdx;
    logic [7:0]  rSrc;
    logic [7:0]  rByte;
    logic        rFirstWr;
    logic        rCpuRdGrant;
    logic        rDone;

    logic        wCpuGrant;
    logic        wTrigger;
    logic        wDmaStep;
    logic        wLastWr;
    logic [7:0]  wWrByte;

    assign wCpuGrant = iCpuReq && ((rState == DMA_IDLE) || isOpenAddr(iCpuAddr));
    assign wTrigger  = wCpuGrant && iCpuWe && (iCpuAddr == DMA_REG_ADDR);
    // The DMA only advances in cycles where the CPU does not own the port.
    assign wDmaStep  = (rState != DMA_IDLE) && !wCpuGrant;
    assign wLastWr   = (rState == DMA_WR) && (rIdx == DMA_LAST_IDX);
    // Source data is still on iMmuData during the first write cycle; after a
    // stall that bus carries CPU data, so the captured copy is used instead.
    assign wWrByte   = rFirstWr ? iMmuData : rByte;

    assign oDmaActive = (rState != DMA_IDLE);
    assign oDmaDone   = rDone;
    assign oCpuData   = rCpuRdGrant ? iMmuData : 8'hFF;

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rState <= DMA_IDLE;
        end else begin
            rState <= wNextState;
        end
    end

    // Next-state logic and MMU port mux (CPU wins whenever granted).
    always_comb begin
        wNextState = rState;
        oMmuAddr   = '0;
        oMmuData   = '0;
        oMmuWe     = 1'b0;

        if (wCpuGrant) begin
            oMmuAddr = iCpuAddr;
            oMmuData = iCpuData;
            oMmuWe   = iCpuWe;
        end else begin
            case (rState)
                DMA_RD: begin
                    oMmuAddr = {rSrc, rIdx};
                end
                DMA_WR: begin
                    oMmuAddr = OAM_BASE + {8'h00, rIdx};
                    oMmuData = wWrByte;
                    oMmuWe   = 1'b1;
                end
                default: begin
                end
            endcase
        end

        if (wTrigger) begin
            wNextState = DMA_RD;
        end else if (wDmaStep) begin
            case (rState)
                DMA_RD:  wNextState = DMA_WR;
                DMA_WR:  wNextState = wLastWr ? DMA_IDLE : DMA_RD;
                default: wNextState = DMA_IDLE;
            endcase
        end
    end

    // DMA index/source/byte registers, done pulse and CPU read-return select.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rIdx        <= '0;
            rSrc        <= '0;
            rByte       <= '0;
            rFirstWr    <= 1'b0;
            rCpuRdGrant <= 1'b0;
            rDone       <= 1'b0;
        end else begin
            rCpuRdGrant <= wCpuGrant && !iCpuWe;
            rDone       <= wDmaStep && wLastWr;
            if (wTrigger) begin
                rSrc     <= iCpuData;
                rIdx     <= '0;
                rFirstWr <= 1'b0;
            end else begin
                if ((rState == DMA_WR) && rFirstWr) begin
                    rByte    <= iMmuData;
                    rFirstWr <= 1'b0;
                end
                if (wDmaStep && (rState == DMA_RD)) begin
                    rFirstWr <= 1'b1;
                end
                if (wDmaStep && (rState == DMA_WR)) begin
                    rIdx <= rIdx + 8'd1;
                end
            end
        end
    end

endmodule
